booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier with an integrated controller, iteration counter and datapath. It is the successor to the fixed two-state Booth control FSM. It adds a generic operand width, a runtime signed/unsigned mode and a full valid/ready handshake on both the input and output sides. It sits between an operand-issuing master and a result consumer, and holds one multiplication in flight at a time.

Parameters:
WIDTH, 16, operand width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH+2), iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock; all state is updated on the rising edge.
reset  input  1  asynchronous, active-low reset; when low, all state goes to its reset value.
in_valid  input  1  operands and mode are valid this cycle.
in_ready  output  1  block can accept operands (high only in IDLE).
signed_mode  input  1  1 = operands are two's-complement; 0 = unsigned. Sampled on accept.
multiplicand  input  WIDTH  operand M, sampled on accept.
multiplier  input  WIDTH  operand Q, sampled on accept.
out_valid  output  1  product is valid (high only in DONE).
out_ready  input  1  consumer takes the product.
product  output  2*WIDTH  result; held stable while out_valid=1.
busy  output  1  high in BUSY and DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, all internal registers=0, product=0, in_ready=1, out_valid=0, busy=0.
- Internal width W1=WIDTH+1. On accept, both operands are extended to W1 bits: sign-extended if signed_mode=1, zero-extended otherwise. This lets one Booth engine serve both modes.
- Registers: A (W1 bits, accumulator), Q (W1 bits), q_1 (1 bit), M (W1 bits), cnt (CNT_W bits).
- FSM states: IDLE, BUSY, DONE. Encoding lives in the package.
- IDLE: in_ready=1. On in_valid=1 at a clock edge (accept): A=0, Q=ext(multiplier), q_1=0, M=ext(multiplicand), cnt=W1, state→BUSY. With in_valid=0, the block stays in IDLE and registers hold.
- BUSY: one Booth step per cycle.
  - Examine {Q[0],q_1}: 01 → A=A+M; 10 → A=A−M; 00 or 11 → A unchanged. All arithmetic is modulo 2^W1.
  - Then arithmetic-shift {A,Q,q_1} right by 1; the MSB of A is replicated.
  - cnt decrements each step. The step that brings cnt to 0 also moves state→DONE and loads product = {A,Q}[2*WIDTH-1:0], using the post-step value.
  - in_ready=0. in_valid and operand inputs are ignored.
- Latency: out_valid rises exactly WIDTH+1 clock edges after the accepting edge.
- DONE: out_valid=1 and product is stable. On out_ready=1 at a clock edge: out_valid→0, state→IDLE. out_ready=0 holds DONE indefinitely (backpressure). No new accept is possible in DONE, since in_ready=0.
- Throughput: one result per WIDTH+3 cycles at best (accept, W1 steps, DONE handshake, back to IDLE).
- product holds its last value after leaving DONE, until the next result is loaded.
- out_ready outside DONE has no effect.
- Reset asserted mid-BUSY or in DONE aborts the operation. The result is discarded and all outputs return to their reset values.
- Overflow: none. The full 2*WIDTH-bit product is always exact in both modes, including signed −2^(WIDTH−1) × −2^(WIDTH−1).
- Illegal or unreachable state encoding → next state IDLE, outputs at IDLE values.

Decomposition:
- Package booth_pkg:
  - typedef enum logic [1:0] state_t {IDLE, BUSY, DONE}
  - typedef enum logic [1:0] booth_op_t {OP_NONE, OP_ADD, OP_SUB}
  - function for the Booth pair decode.
- Sub-module booth_step (purely combinational, parametrised on W1):
  - inputs A, Q, q_1, M
  - outputs next A, Q, q_1 (add/sub followed by arithmetic shift)
  - The top level keeps the FSM, counter, handshakes and registers.

Test Plan:
- WIDTH=8, signed_mode=1, M=8'hFD (−3), Q=8'h05: out_valid high exactly 9 cycles after accept; product=16'hFFF1 (−15).
- WIDTH=8, signed_mode=0, M=8'hFF, Q=8'hFF: product=16'hFE01 (65025). The same operands with signed_mode=1 give product=16'h0001.
- WIDTH=8, signed_mode=1, M=8'h80, Q=8'h80: product=16'h4000. Then M=8'h00, Q=8'h80: product=16'h0000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. Required: product stable, out_valid=1, in_ready=0, and an in_valid pulse in this window is ignored. Then out_ready=1: IDLE on the next edge, in_ready=1.
- Reset mid-operation: accept M=8'h07, Q=8'h06, then assert reset 4 cycles later. Required: immediate (asynchronous) return to in_ready=1, out_valid=0, busy=0, product=0. A following accept of 7×6 yields 16'h002A with no stale state.
- Random regression for WIDTH ∈ {2,8,16,33}, both modes: product matches a reference model; latency is WIDTH+1 for every transaction.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier.
//   state_t    : controller states (IDLE / BUSY / DONE)
//   booth_op_t : action selected by the radix-2 Booth pair {Q[0], q_1}
//   booth_decode() : maps the Booth pair to an add / subtract / no-op
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_t;

  // 01 : end of a run of ones  -> add M
  // 10 : start of a run of ones -> subtract M
  // 00 / 11 : inside a run      -> nothing
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration on W1-bit registers.
//   a, q, q_1, m       : current accumulator, multiplier, guard bit, multiplicand
//   a_nxt, q_nxt, q_1_nxt : state after add/sub and arithmetic right shift
// All arithmetic wraps modulo 2^W1.
module booth_step
  import booth_pkg::*;
#(
  parameter int W1 = 17
) (
  input  logic [W1-1:0] a,
  input  logic [W1-1:0] q,
  input  logic          q_1,
  input  logic [W1-1:0] m,
  output logic [W1-1:0] a_nxt,
  output logic [W1-1:0] q_nxt,
  output logic          q_1_nxt
);

  booth_op_t       op;
  logic [W1-1:0]   sum;

  always_comb begin
    op  = booth_decode(q[0], q_1);
    sum = a;
    case (op)
      OP_ADD:  sum = a + m;
      OP_SUB:  sum = a - m;
      default: sum = a;
    endcase
  end

  // Arithmetic shift of {sum, q, q_1} right by one: sign of sum is replicated,
  // sum's LSB moves into Q, Q's LSB becomes the new guard bit.
  assign a_nxt   = {sum[W1-1], sum[W1-1:1]};
  assign q_nxt   = {sum[0], q[W1-1:1]};
  assign q_1_nxt = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one multiplication in flight.
// Operands are widened to WIDTH+1 bits (sign- or zero-extended by signed_mode)
// so the same signed Booth engine produces exact signed and unsigned products.
//   clk, reset        : clock, asynchronous active-low reset
//   in_valid/in_ready : operand handshake (ready only in IDLE)
//   signed_mode       : 1 = two's complement operands, 0 = unsigned
//   multiplicand      : M, multiplier : Q  (sampled on accept)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   product           : 2*WIDTH-bit result, held until the next result loads
//   busy              : high in BUSY and DONE
// Latency: out_valid rises WIDTH+1 edges after the accepting edge.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int W1 = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t          state;
  logic [W1-1:0]   a_r, q_r, m_r;
  logic            q1_r;
  logic [CNT_W-1:0] cnt;

  logic [W1-1:0]   a_nxt, q_nxt;
  logic            q1_nxt;
  logic [W1-1:0]   m_ext, q_ext;

  // Extension bit is the operand MSB only in signed mode.
  assign m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
  assign q_ext = {signed_mode & multiplier[WIDTH-1],   multiplier};

  booth_step #(.W1(W1)) u_step (
    .a       (a_r),
    .q       (q_r),
    .q_1     (q1_r),
    .m       (m_r),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q1_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      a_r     <= '0;
      q_r     <= '0;
      q1_r    <= 1'b0;
      m_r     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        BUSY: begin
          a_r  <= a_nxt;
          q_r  <= q_nxt;
          q1_r <= q1_nxt;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
            // Low 2*WIDTH bits of the post-step {A,Q}; the top two bits of A
            // are only sign copies of the exact product.
            product <= {a_nxt[WIDTH-2:0], q_nxt};
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        // IDLE, and any illegal encoding, behaves as IDLE: in_ready is high
        // there, so an offered operand pair is taken rather than dropped.
        default: begin
          if (in_valid) begin
            a_r   <= '0;
            q_r   <= q_ext;
            q1_r  <= 1'b0;
            m_r   <= m_ext;
            cnt   <= CNT_INIT;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign in_ready  = (state != BUSY) && (state != DONE);
  assign busy      = ~in_ready;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboarded bench for booth_mult_seq at WIDTH 8 (directed + random),
// 2, 8, 16 and 33 (random). Expected products come from plain integer
// multiplication of the extended operands.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;

  localparam int NI = 5;

  function automatic int wid(input int i);
    case (i)
      0: return 8;
      1: return 2;
      2: return 8;
      3: return 16;
      default: return 33;
    endcase
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int W = wid(gi);

    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             signed_mode = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     mcand = '0;
    logic [W-1:0]     mplier = '0;
    logic             in_ready, out_valid, busy;
    logic [2*W-1:0]   product;

    logic [2*W-1:0]   q_prod[$];
    int               q_acc[$];
    int               rdy_mode = 0;
    bit               seen = 1'b0;
    logic [2*W-1:0]   held = '0;

    booth_mult_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .signed_mode  (signed_mode),
      .multiplicand (mcand),
      .multiplier   (mplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vecs++;
      if (act !== exp) begin
        errs++;
        $display("FAIL w%0d %s: got %0h want %0h (t=%0t)", W, name, act, exp, $time);
      end
    endtask

    // Reference: extend to 2W+2 bits, multiply, keep the low 2W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sm);
      logic [2*W+1:0] ea, eb, p;
      ea = sm ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
      eb = sm ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
      p  = ea * eb;
      return p[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_op();
      logic [63:0]  r;
      logic [W-1:0] v;
      r = {$urandom, $urandom};
      v = '0;
      case ($urandom_range(0, 5))
        0: v = '0;
        1: v = '1;
        2: v[W-1] = 1'b1;
        3: begin v = '1; v[W-1] = 1'b0; end
        default: v = r[W-1:0];
      endcase
      return v;
    endfunction

    // Monitor: pops the scoreboard on each new result, checks value and
    // latency, then checks the result stays put while backpressured.
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (out_valid && !seen) begin
          check("result_expected", 128'(q_prod.size() != 0), 128'(1));
          if (q_prod.size() != 0) begin
            logic [2*W-1:0] e;
            int a;
            e = q_prod.pop_front();
            a = q_acc.pop_front();
            check("product", 128'(product), 128'(e));
            check("latency", 128'(cyc - a), 128'(W + 1));
            check("busy_in_done", 128'(busy), 128'(1));
            check("in_ready_in_done", 128'(in_ready), 128'(0));
          end
          seen = 1'b1;
          held = product;
        end else if (out_valid) begin
          check("product_hold", 128'(product), 128'(held));
        end
        if (!out_valid) seen = 1'b0;
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 3) != 0);
          default: out_ready = 1'b0;
        endcase
      end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        check("accept_timeout", 128'(in_ready), 128'(1));
        return;
      end
      mcand = a; mplier = b; signed_mode = sm; in_valid = 1'b1;
      q_prod.push_back(ref_mul(a, b, sm));
      q_acc.push_back(cyc + 1);
      @(negedge clk);
      // Garbage on the operand bus while busy must not matter.
      in_valid = 1'b0;
      mcand = rnd_op(); mplier = rnd_op(); signed_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
      int n = 0;
      while ((q_prod.size() != 0 || out_valid) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("drain", 128'(q_prod.size()), 128'(0));
    endtask

    task automatic rand_run(input int n);
      rdy_mode = 1;
      repeat (n) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      end
      drain();
    endtask

    if (gi == 0) begin : g_dir
      initial begin
        int n;
        #3 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_product", 128'(product), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        rdy_mode = 0;
        send(8'hFD, 8'h05, 1'b1);
        send(8'hFF, 8'hFF, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'h80, 8'h80, 1'b1);
        send(8'h00, 8'h80, 1'b1);
        drain();

        // Backpressure window with an ignored in_valid pulse.
        rdy_mode = 2;
        send(8'h0C, 8'h0B, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("bp_valid_rise", 128'(out_valid), 128'(1));
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_out_valid", 128'(out_valid), 128'(1));
          check("bp_in_ready", 128'(in_ready), 128'(0));
          if (k == 1) begin
            in_valid = 1'b1; mcand = 8'h11; mplier = 8'h22;
          end else begin
            in_valid = 1'b0;
          end
        end
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_in_ready", 128'(in_ready), 128'(1));
        check("bp_idle_out_valid", 128'(out_valid), 128'(0));
        repeat (3) begin
          @(negedge clk);
          check("bp_pulse_ignored", 128'(busy), 128'(0));
        end

        // Reset in the middle of a multiplication.
        send(8'h07, 8'h06, 1'b0);
        repeat (4) @(posedge clk);
        #1 check("busy_before_reset", 128'(busy), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 128'(in_ready), 128'(1));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_product", 128'(product), 128'(0));
        q_prod.delete();
        q_acc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h07, 8'h06, 1'b0);
        drain();

        rand_run(150);
        done_cnt++;
      end
    end else begin : g_rnd
      initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rand_run(100);
        done_cnt++;
      end
    end
  end

  initial begin
    int n = 0;
    while (done_cnt < NI && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < NI) begin
      vecs++;
      errs++;
      $display("FAIL timeout: %0d of %0d streams finished", done_cnt, NI);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
